alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised execute-stage arithmetic unit for the pipelined MIPS core. It extends the single-cycle integer ALU with XOR, NOR, unsigned compare, shifts and a zero flag. It adds an iterative multiply/divide unit (MDU) that owns the HI/LO registers and uses a start/busy/done handshake. The pipeline controller stalls on `busy` and reads HI/LO through MFHI/MFLO codes on the same result port.

## Interface
- `DATA_WIDTH`, 32, operand/result width; must be ≥4 and a power of two
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `srcA`  in  DATA_WIDTH  operand A (dividend / multiplicand)
- `srcB`  in  DATA_WIDTH  operand B (divisor / multiplier / shift amount)
- `alu_control`  in  4  combinational operation select
- `start`  in  1  launch MDU operation; sampled only when `busy`=0
- `md_op`  in  2  MDU op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `alu_result`  out  DATA_WIDTH  combinational result
- `zero`  out  1  `alu_result` == 0
- `busy`  out  1  MDU operation in progress (registered)
- `done`  out  1  one-cycle pulse: HI/LO just updated (registered)
- `div_by_zero`  out  1  set with `done` when a divide had `srcB`=0; cleared by the next `start`
- `hi`, `lo`  out  DATA_WIDTH each  HI/LO registers

## Operation
- `alu_control` decode (combinational):
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 NOR
  - 0101 SLTU (unsigned); 0110 SUB; 0111 SLT (signed two's complement)
  - 1000 SLL; 1001 SRL; 1010 SRA. Each shifts `srcA` by `srcB[log2(DATA_WIDTH)-1:0]`.
  - 1011 MFHI (= `hi`); 1100 MFLO (= `lo`); all other codes give 0.
- ADD/SUB wrap modulo 2^DATA_WIDTH. No overflow flag.
- SLT/SLTU produce the value 1 or 0, zero-extended.
- MFHI/MFLO return the current register value, even while `busy`. Stale reads are the controller's responsibility.
- MDU FSM states: IDLE, CALC, FIN.
  - IDLE: when `start`=1, latch `md_op`. For signed ops, latch operand magnitudes and the result signs. Load iteration counter with DATA_WIDTH-1, go to CALC, `busy`←1, `div_by_zero`←0.
  - CALC: one iteration per cycle. Multiply: shift-add of 2·DATA_WIDTH product. Divide: restoring, one quotient bit per cycle. At counter 0, go to FIN.
  - FIN: apply sign correction and write HI/LO. Set `done`←1 for one cycle, `busy`←0, go to IDLE.
- Multiply: {HI,LO} = full 2·DATA_WIDTH product, signed or unsigned.
- Divide: LO = quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
- Divide by zero (`srcB`=0 at start, signed or unsigned):
  - Run the full latency; no early exit.
  - LO = all ones, HI = `srcA`, `div_by_zero`=1 with `done`.
- Signed overflow (most-negative ÷ −1): LO = most-negative, HI = 0.
- `start` while `busy`=1 is ignored; no queueing, no error.
- `start` and FIN in the same cycle: that `start` is ignored, because `busy` is still 1.
- Combinational ops stay fully usable while the MDU is busy.

## Timing
- Reset (async, immediate on `rst_n` low, including mid-operation):
  - state IDLE, counter 0
  - `hi`=`lo`=0, `busy`=0, `done`=0, `div_by_zero`=0
  - an in-flight operation is discarded.
- Combinational path from `srcA`/`srcB`/`alu_control` to `alu_result`/`zero` has zero cycles of latency.
- Start sampled at edge E0. `busy` is high from E0 until E(DATA_WIDTH+1).
- At edge E(DATA_WIDTH+1):
  - HI/LO updated
  - `done`=1 for the following cycle only
  - `busy`=0
- Latency: DATA_WIDTH+1 cycles, identical for all four MDU ops. For 32 bits, `done` goes high 33 cycles after the start edge.
- Back-to-back: a new `start` is accepted in the cycle where `done`=1, at edge E(DATA_WIDTH+2) relative to the first start.
- HI/LO hold their value between operations. Their previous values stay visible until FIN.

## Test plan
- Combinational ops, `srcA`=0xFFFFFFFF, `srcB`=0x00000001:
  - ADD → 0x00000000 with `zero`=1; SLT → 1; SLTU → 0
  - SRA by 4 of 0x80000000 → 0xF8000000
- MULT, −3 × 7 (0xFFFFFFFD, 0x00000007):
  - `busy` high 33 cycles, `done` pulse 33 cycles after start
  - `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB
- MULTU, 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- DIV, −7 ÷ 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIV, 0x80000000 ÷ 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU, 7 ÷ 0 → `lo`=0xFFFFFFFF, `hi`=0x00000007, `div_by_zero`=1 at `done`.
- Handshake and reset:
  - Second `start` at cycle 5 of a MULT is ignored; the result matches the first op only.
  - `rst_n` pulsed low at cycle 10 of a DIV → `busy`, `hi`, `lo` all 0 immediately, and no `done` follows.
  - A fresh `start` after reset completes normally with 33-cycle latency.

Source files
------------

// File: rtl/alu_mdu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_mdu : execute-stage ALU with iterative multiply/divide and HI/LO regs  |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module alu_mdu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] srcA,
  input  logic [DATA_WIDTH-1:0] srcB,
  input  logic [3:0]            alu_control,
  input  logic                  start,
  input  logic [1:0]            md_op,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  zero,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int              c_SHW      = $clog2(DATA_WIDTH);
  localparam logic [c_SHW-1:0] c_CNT_LAST = c_SHW'(DATA_WIDTH - 1);
  localparam logic [c_SHW-1:0] c_CNT_ONE  = c_SHW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [c_SHW-1:0]        r_cnt;
  logic [DATA_WIDTH-1:0]   r_acc_hi, r_acc_lo, r_opb;
  logic                    r_is_div, r_neg_q, r_neg_r, r_b_zero;
  logic                    r_busy, r_done, r_dbz;
  logic [DATA_WIDTH-1:0]   r_hi, r_lo;

  logic [c_SHW-1:0]        w_shamt;
  logic                    w_signed, w_neg_a, w_neg_b;
  logic [DATA_WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [DATA_WIDTH:0]     w_add, w_mul_top, w_trial;
  logic [2*DATA_WIDTH-1:0] w_mul_nxt, w_prod_fix;
  logic                    w_fits;
  logic [DATA_WIDTH-1:0]   w_div_hi, w_div_lo, w_quo, w_rem;

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

  // Single-cycle ALU, independent of the MDU state
  always_comb begin
    w_shamt    = srcB[c_SHW-1:0];
    alu_result = '0;
    case (alu_control)
      4'b0000: alu_result = srcA & srcB;
      4'b0001: alu_result = srcA | srcB;
      4'b0010: alu_result = srcA + srcB;
      4'b0011: alu_result = srcA ^ srcB;
      4'b0100: alu_result = ~(srcA | srcB);
      4'b0101: alu_result = {{(DATA_WIDTH-1){1'b0}}, (srcA < srcB)};
      4'b0110: alu_result = srcA - srcB;
      4'b0111: alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      4'b1000: alu_result = srcA << w_shamt;
      4'b1001: alu_result = srcA >> w_shamt;
      4'b1010: alu_result = $unsigned($signed(srcA) >>> w_shamt);
      4'b1011: alu_result = r_hi;
      4'b1100: alu_result = r_lo;
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  // Launch-time operand magnitudes; md_op[0]=0 selects the signed variants
  always_comb begin
    w_signed = ~md_op[0];
    w_neg_a  = w_signed & srcA[DATA_WIDTH-1];
    w_neg_b  = w_signed & srcB[DATA_WIDTH-1];
    w_mag_a  = w_neg_a ? -srcA : srcA;
    w_mag_b  = w_neg_b ? -srcB : srcB;
  end

  // One iteration: multiply keeps multiplier in acc_lo and shifts product in from the top;
  // divide keeps dividend in acc_lo, shifting quotient bits in at the bottom.
  always_comb begin
    w_add     = {1'b0, r_acc_hi} + {1'b0, r_opb};
    w_mul_top = r_acc_lo[0] ? w_add : {1'b0, r_acc_hi};
    w_mul_nxt = {w_mul_top, r_acc_lo[DATA_WIDTH-1:1]};
    w_trial   = {r_acc_hi, r_acc_lo[DATA_WIDTH-1]} - {1'b0, r_opb};
    w_fits    = ~w_trial[DATA_WIDTH];
    w_div_hi  = w_fits ? w_trial[DATA_WIDTH-1:0] : {r_acc_hi[DATA_WIDTH-2:0], r_acc_lo[DATA_WIDTH-1]};
    w_div_lo  = {r_acc_lo[DATA_WIDTH-2:0], w_fits};
  end

  // Sign correction; a zero divisor still leaves |dividend| as the remainder
  always_comb begin
    w_prod_fix = r_neg_q ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
    w_quo      = r_b_zero ? '1 : (r_neg_q ? -r_acc_lo : r_acc_lo);
    w_rem      = r_neg_r ? -r_acc_hi : r_acc_hi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_CALC;
      S_CALC:  if (r_cnt == '0) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opb    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_div <= md_op[1];
            r_acc_hi <= '0;
            r_acc_lo <= md_op[1] ? w_mag_a : w_mag_b;
            r_opb    <= md_op[1] ? w_mag_b : w_mag_a;
            r_neg_q  <= w_neg_a ^ w_neg_b;
            r_neg_r  <= w_neg_a;
            r_b_zero <= (srcB == '0);
            r_cnt    <= c_CNT_LAST;
            r_busy   <= 1'b1;
            r_dbz    <= 1'b0;
          end
        end
        S_CALC: begin
          if (r_is_div) begin
            r_acc_hi <= w_div_hi;
            r_acc_lo <= w_div_lo;
          end else begin
            {r_acc_hi, r_acc_lo} <= w_mul_nxt;
          end
          if (r_cnt != '0) r_cnt <= r_cnt - c_CNT_ONE;
        end
        S_FIN: begin
          if (r_is_div) begin
            r_hi  <= w_rem;
            r_lo  <= w_quo;
            r_dbz <= r_b_zero;
          end else begin
            {r_hi, r_lo} <= w_prod_fix;
          end
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_mdu : randomized self-checking bench for alu_mdu                    |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_alu_mdu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] srcA, srcB;
  logic [3:0]   alu_control;
  logic         start;
  logic [1:0]   md_op;
  logic [W-1:0] alu_result;
  logic         zero, busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] exp_hi, exp_lo;

  alu_mdu #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .srcA(srcA), .srcB(srcB),
    .alu_control(alu_control), .start(start), .md_op(md_op),
    .alu_result(alu_result), .zero(zero), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  function automatic logic [W-1:0] alu_ref(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] h, input logic [W-1:0] l);
    int unsigned  s;
    longint       sa, sb;
    logic [W-1:0] ones;
    s    = b % W;
    sa   = $signed(a);
    sb   = $signed(b);
    ones = '1;
    case (c)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd4:  return ~(a | b);
      4'd5:  return (a < b) ? 1 : 0;
      4'd6:  return a - b;
      4'd7:  return (sa < sb) ? 1 : 0;
      4'd8:  return a << s;
      4'd9:  return a >> s;
      4'd10: return (a >> s) | (a[W-1] ? ~(ones >> s) : '0);
      4'd11: return h;
      4'd12: return l;
      default: return '0;
    endcase
  endfunction

  task automatic md_ref(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
    logic [2*W-1:0] p;
    longint         sa, sb, q, r;
    sa = $signed(a);
    sb = $signed(b);
    dz = 1'b0;
    p  = '0;
    h  = '0;
    l  = '0;
    case (op)
      2'd0: begin p = sa * sb; {h, l} = p; end
      2'd1: begin p = 64'(a) * 64'(b); {h, l} = p; end
      default: begin
        if (b == '0) begin
          l  = '1;
          h  = a;
          dz = 1'b1;
        end else if (op == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          l = W'(q);
          h = W'(r);
        end else begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endtask

  task automatic comb_exp(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] expv);
    alu_control = c;
    srcA        = a;
    srcB        = b;
    #1;
    check_eq(tag, alu_result, expv);
    check_eq({tag, "_zero"}, zero, (expv == '0));
  endtask

  // Starts an op in the current cycle; returns in the cycle where done is high.
  task automatic run_md(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int extra_k);
    logic [W-1:0] eh, el, sum;
    logic         edz, seen, gap;
    int           k;
    md_ref(op, a, b, eh, el, edz);
    sum         = a + b;
    md_op       = op;
    srcA        = a;
    srcB        = b;
    alu_control = 4'b0010;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy_at_start", busy, 1'b1);
    check_eq("done_pulse_width", done, 1'b0);
    k    = 0;
    seen = 1'b0;
    gap  = 1'b0;
    while (!seen && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (done) seen = 1'b1;
      else if (busy !== 1'b1) gap = 1'b1;
      if (k == 3) check_eq("alu_while_busy", alu_result, sum);
      if (k == W / 2) begin
        check_eq("hi_hold", hi, exp_hi);
        check_eq("lo_hold", lo, exp_lo);
      end
      if (extra_k != 0 && k == extra_k) begin
        start = 1'b1;
        md_op = ~op;
        srcA  = $urandom;
        srcB  = $urandom;
      end
      if (extra_k != 0 && k == extra_k + 1) start = 1'b0;
    end
    check_eq("done_seen", seen, 1'b1);
    check_eq("latency", k, W + 1);
    check_eq("busy_span", gap, 1'b0);
    check_eq("busy_clear", busy, 1'b0);
    check_eq("hi", hi, eh);
    check_eq("lo", lo, el);
    check_eq("div_by_zero", div_by_zero, edz);
    exp_hi = eh;
    exp_lo = el;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    logic [3:0]   c;
    logic [1:0]   op;
    logic         saw;
    int           sel;

    rst_n = 1'b0; start = 1'b0; md_op = 2'b00;
    srcA = '0; srcB = '0; alu_control = 4'b0000;
    exp_hi = '0; exp_lo = '0;
    repeat (2) @(posedge clk); #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_dbz", div_by_zero, 1'b0);
    check_eq("rst_hi", hi, '0);
    check_eq("rst_lo", lo, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    comb_exp("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    comb_exp("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    comb_exp("sltu_big", 4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    comb_exp("sra4", 4'b1010, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000);
    for (int i = 0; i < 64; i++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if (i % 8 == 0) b = a;
      comb_exp("alu_rand", c, a, b, alu_ref(c, a, b, exp_hi, exp_lo));
    end
    @(posedge clk); #1;

    run_md(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 5);
    @(posedge clk); #1;
    comb_exp("mfhi", 4'b1011, '0, '0, exp_hi);
    comb_exp("mflo", 4'b1100, '0, '0, exp_lo);
    run_md(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_md(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_md(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    @(posedge clk); #1;
    run_md(2'd3, 32'h0000_0007, 32'h0000_0000, 0);

    // Abort a divide with an asynchronous reset
    md_op = 2'd2; srcA = 32'h1234_5678; srcB = 32'h0000_0013; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_hi", hi, '0);
    check_eq("arst_lo", lo, '0);
    check_eq("arst_dbz", div_by_zero, 1'b0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    saw    = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw = 1'b1;
    end
    check_eq("no_done_after_rst", saw, 1'b0);
    run_md(2'd2, 32'h1234_5678, 32'h0000_0013, 0);

    for (int i = 0; i < 14; i++) begin
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 5);
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 32'h8000_0000; b = '1; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
      run_md(op, a, b, 0);
    end

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
